// File: rtl/dma_rd_arbiter_if.sv
// Bundle between the three layer-load requesters, the arbiter and the DMA
// read-command channel. The arbiter sits on the master modport. The
// requesters and the DMA sit on the slave modport.
interface dma_rd_arbiter_if #(
  parameter int unsigned ADDRLEN = 32,
  parameter int unsigned LENW    = 16
);
  // Requester side: bit0 input tile, bit1 kernel, bit2 sparse index
  logic [2:0]         req;
  logic [ADDRLEN-1:0] addrin;
  logic [ADDRLEN-1:0] addrkrnl;
  logic [ADDRLEN-1:0] addrindx;
  logic [LENW-1:0]    lenin;
  logic [LENW-1:0]    lenkrnl;
  logic [LENW-1:0]    lenindx;
  logic [2:0]         gnt;
  logic [2:0]         done;
  logic               busy;

  // DMA read-command channel
  logic               rdvalid;
  logic               rdready;
  logic [ADDRLEN-1:0] rdaddr;
  logic [LENW-1:0]    transferlen;
  logic               rdlast;

  modport master (
    input  req,
    input  addrin,
    input  addrkrnl,
    input  addrindx,
    input  lenin,
    input  lenkrnl,
    input  lenindx,
    output gnt,
    output done,
    output busy,
    output rdvalid,
    input  rdready,
    output rdaddr,
    output transferlen,
    input  rdlast
  );

  modport slave (
    output req,
    output addrin,
    output addrkrnl,
    output addrindx,
    output lenin,
    output lenkrnl,
    output lenindx,
    input  gnt,
    input  done,
    input  busy,
    input  rdvalid,
    output rdready,
    input  rdaddr,
    input  transferlen,
    output rdlast
  );
endinterface

// File: rtl/dma_rd_arbiter.sv
// Round-robin owner of the single DMA read-command channel. Serves one
// requester at a time and splits long transfers into chunks of at most
// MAXLEN bytes. Each chunk waits for the rdlast of the previous one. The
// owner gets a one-cycle done pulse when its whole transfer has landed.
module dma_rd_arbiter #(
  parameter int unsigned ADDRLEN = 32,
  parameter int unsigned LENW    = 16,
  parameter int unsigned MAXLEN  = 4096
) (
  input logic              clk,
  input logic              rst,
  dma_rd_arbiter_if.master bus
);

  localparam logic [LENW-1:0] MaxLen = LENW'(MAXLEN);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         sel_q;
  logic [ADDRLEN-1:0] cur_addr_q;
  logic [LENW-1:0]    rem_q;
  logic [2:0]         gnt_q;
  logic [2:0]         done_q;
  logic               busy_q;
  logic               rdvalid_q;
  logic [ADDRLEN-1:0] rdaddr_q;
  logic [LENW-1:0]    transferlen_q;

  logic [1:0]         sel_nxt;
  logic [ADDRLEN-1:0] req_addr;
  logic [LENW-1:0]    req_len;
  logic [LENW-1:0]    req_chunk;
  logic [ADDRLEN-1:0] next_addr;
  logic [LENW-1:0]    next_rem;
  logic [LENW-1:0]    next_chunk;
  logic [1:0]         ptr_nxt;

  function automatic logic [2:0] onehot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  function automatic logic [LENW-1:0] clip(input logic [LENW-1:0] len);
    return (len > MaxLen) ? MaxLen : len;
  endfunction

  // Rotating scan starting at ptr; only meaningful when some req bit is set
  always_comb begin
    sel_nxt = 2'd0;
    case (ptr_q)
      2'd1: begin
        if (bus.req[1])      sel_nxt = 2'd1;
        else if (bus.req[2]) sel_nxt = 2'd2;
        else                 sel_nxt = 2'd0;
      end
      2'd2: begin
        if (bus.req[2])      sel_nxt = 2'd2;
        else if (bus.req[0]) sel_nxt = 2'd0;
        else                 sel_nxt = 2'd1;
      end
      default: begin
        if (bus.req[0])      sel_nxt = 2'd0;
        else if (bus.req[1]) sel_nxt = 2'd1;
        else                 sel_nxt = 2'd2;
      end
    endcase
  end

  // Address/length of the requester about to be granted
  always_comb begin
    req_addr = bus.addrindx;
    req_len  = bus.lenindx;
    case (sel_nxt)
      2'd0: begin
        req_addr = bus.addrin;
        req_len  = bus.lenin;
      end
      2'd1: begin
        req_addr = bus.addrkrnl;
        req_len  = bus.lenkrnl;
      end
      default: begin
        req_addr = bus.addrindx;
        req_len  = bus.lenindx;
      end
    endcase
  end

  // Progress after the chunk in flight completes; address wraps modulo 2^ADDRLEN
  always_comb begin
    req_chunk  = clip(req_len);
    next_addr  = cur_addr_q + ADDRLEN'(transferlen_q);
    next_rem   = rem_q - transferlen_q;
    next_chunk = clip(next_rem);
    ptr_nxt    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
  end

  // Service FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= 2'd0;
      sel_q         <= 2'd0;
      cur_addr_q    <= '0;
      rem_q         <= '0;
      gnt_q         <= 3'b000;
      done_q        <= 3'b000;
      busy_q        <= 1'b0;
      rdvalid_q     <= 1'b0;
      rdaddr_q      <= '0;
      transferlen_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req != 3'b000) begin
            sel_q      <= sel_nxt;
            gnt_q      <= onehot(sel_nxt);
            busy_q     <= 1'b1;
            cur_addr_q <= req_addr;
            rem_q      <= req_len;
            if (req_len == '0) begin
              // Nothing to fetch: complete straight away
              done_q  <= onehot(sel_nxt);
              state_q <= StDone;
            end else begin
              rdvalid_q     <= 1'b1;
              rdaddr_q      <= req_addr;
              transferlen_q <= req_chunk;
              state_q       <= StIssue;
            end
          end
        end
        StIssue: begin
          // Command fields stay untouched until the DMA takes them
          if (rdvalid_q && bus.rdready) begin
            rdvalid_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (bus.rdlast) begin
            cur_addr_q <= next_addr;
            rem_q      <= next_rem;
            if (next_rem == '0) begin
              done_q  <= onehot(sel_q);
              state_q <= StDone;
            end else begin
              rdvalid_q     <= 1'b1;
              rdaddr_q      <= next_addr;
              transferlen_q <= next_chunk;
              state_q       <= StIssue;
            end
          end
        end
        StDone: begin
          gnt_q   <= 3'b000;
          done_q  <= 3'b000;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_nxt;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.rdvalid     = rdvalid_q;
  assign bus.rdaddr      = rdaddr_q;
  assign bus.transferlen = transferlen_q;

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Bench for dma_rd_arbiter: directed scenarios followed by randomized
// services. Everything is checked against a transaction-level model. The
// model keeps the last served requester and computes chunks arithmetically.
module tb_dma_rd_arbiter;
  localparam int unsigned ADDRLEN = 32;
  localparam int unsigned LENW    = 16;
  localparam int unsigned MAXLEN  = 4096;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_rd_arbiter_if #(.ADDRLEN(ADDRLEN), .LENW(LENW)) bus ();

  dma_rd_arbiter #(
    .ADDRLEN (ADDRLEN),
    .LENW    (LENW),
    .MAXLEN  (MAXLEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int last_owner = 2;  // model: requester served most recently
  logic [ADDRLEN-1:0] cmd_addr_q[$];
  int                 cmd_len_q[$];
  logic [2:0]         gnt_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin: first requesting index after the last one served
  function automatic int model_pick(input logic [2:0] r);
    for (int k = 1; k <= 3; k++) begin
      int idx;
      idx = (last_owner + k) % 3;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [LENW-1:0] rand_len();
    int mode;
    mode = $urandom_range(4, 0);
    case (mode)
      0:       return '0;
      1:       return LENW'($urandom_range(MAXLEN, 1));
      2:       return LENW'(MAXLEN * $urandom_range(3, 1));
      default: return LENW'($urandom_range(3 * MAXLEN + 500, 1));
    endcase
  endfunction

  task automatic reset_dut();
    rst         = 1'b1;
    bus.req     = 3'b000;
    bus.rdready = 1'b0;
    bus.rdlast  = 1'b0;
    tick();
    tick();
    chk("rst_gnt", 64'(bus.gnt), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_rdvalid", 64'(bus.rdvalid), 64'(0));
    chk("rst_rdaddr", 64'(bus.rdaddr), 64'(0));
    chk("rst_transferlen", 64'(bus.transferlen), 64'(0));
    rst        = 1'b0;
    last_owner = 2;
  endtask

  // One full service starting from IDLE, with req already presented.
  task automatic service(input int stall_lo, input int stall_hi, input int lat_lo,
                         input int lat_hi, input bit scramble, input bit mid_en,
                         input logic [2:0] mid_req);
    int owner;
    int rem;
    int c;
    int n;
    logic [2:0] oh;
    logic [ADDRLEN-1:0] a;
    owner = model_pick(bus.req);
    if (owner < 0) begin
      $display("FAIL tb_setup: service started with req=0");
      $fatal(1);
    end
    oh = 3'b001 << owner;
    case (owner)
      0:       begin a = bus.addrin;   rem = int'(bus.lenin);   end
      1:       begin a = bus.addrkrnl; rem = int'(bus.lenkrnl); end
      default: begin a = bus.addrindx; rem = int'(bus.lenindx); end
    endcase
    cmd_addr_q.delete();
    cmd_len_q.delete();
    tick();
    gnt_seen = bus.gnt;
    chk("grant", 64'(bus.gnt), 64'(oh));
    chk("grant_busy", 64'(bus.busy), 64'(1));
    if (scramble) begin
      // Inputs after grant must not disturb the service
      bus.addrin   = $urandom;
      bus.addrkrnl = $urandom;
      bus.addrindx = $urandom;
      bus.lenin    = LENW'($urandom);
      bus.lenkrnl  = LENW'($urandom);
      bus.lenindx  = LENW'($urandom);
      bus.req      = 3'($urandom_range(7, 0));
    end
    if (mid_en) bus.req = mid_req;
    while (rem > 0) begin
      c = (rem > int'(MAXLEN)) ? int'(MAXLEN) : rem;
      chk("cmd_rdvalid", 64'(bus.rdvalid), 64'(1));
      chk("cmd_rdaddr", 64'(bus.rdaddr), 64'(a));
      chk("cmd_len", 64'(bus.transferlen), 64'(c));
      chk("cmd_done_low", 64'(bus.done), 64'(0));
      chk("cmd_gnt", 64'(bus.gnt), 64'(oh));
      cmd_addr_q.push_back(bus.rdaddr);
      cmd_len_q.push_back(int'(bus.transferlen));
      bus.rdready = 1'b0;
      n = $urandom_range(stall_hi, stall_lo);
      repeat (n) begin
        bus.rdlast = 1'($urandom_range(1, 0));  // outside WAIT: ignored
        tick();
        chk("stall_rdvalid", 64'(bus.rdvalid), 64'(1));
        chk("stall_rdaddr", 64'(bus.rdaddr), 64'(a));
        chk("stall_len", 64'(bus.transferlen), 64'(c));
      end
      bus.rdlast  = 1'b0;
      bus.rdready = 1'b1;
      tick();
      chk("accept_rdvalid", 64'(bus.rdvalid), 64'(0));
      bus.rdready = 1'($urandom_range(1, 0));  // no rdvalid: ignored
      n = $urandom_range(lat_hi, lat_lo);
      repeat (n - 1) begin
        tick();
        chk("wait_rdvalid", 64'(bus.rdvalid), 64'(0));
        chk("wait_busy", 64'(bus.busy), 64'(1));
      end
      bus.rdlast = 1'b1;
      tick();
      bus.rdlast  = 1'b0;
      bus.rdready = 1'b0;
      rem = rem - c;
      a   = a + ADDRLEN'(c);
    end
    chk("done_pulse", 64'(bus.done), 64'(oh));
    chk("done_gnt", 64'(bus.gnt), 64'(oh));
    chk("done_rdvalid", 64'(bus.rdvalid), 64'(0));
    tick();
    chk("idle_gnt", 64'(bus.gnt), 64'(0));
    chk("idle_done", 64'(bus.done), 64'(0));
    chk("idle_busy", 64'(bus.busy), 64'(0));
    last_owner = owner;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req      = 3'b000;
    bus.addrin   = '0;
    bus.addrkrnl = '0;
    bus.addrindx = '0;
    bus.lenin    = '0;
    bus.lenkrnl  = '0;
    bus.lenindx  = '0;
    bus.rdready  = 1'b0;
    bus.rdlast   = 1'b0;
    rst          = 1'b1;

    reset_dut();

    // Basic input load, rdlast 10 cycles after acceptance
    bus.req    = 3'b001;
    bus.addrin = 32'h0;
    bus.lenin  = 16'd1000;
    service(0, 0, 10, 10, 1'b0, 1'b1, 3'b000);
    chk("basic_ncmd", 64'(cmd_len_q.size()), 64'(1));
    chk("basic_len", 64'(cmd_len_q[0]), 64'(1000));

    // Chunking of a 10000-byte kernel load
    bus.req      = 3'b010;
    bus.addrkrnl = 32'hF00;
    bus.lenkrnl  = 16'd10000;
    service(0, 2, 1, 5, 1'b0, 1'b1, 3'b000);
    chk("chunk_ncmd", 64'(cmd_len_q.size()), 64'(3));
    chk("chunk0_addr", 64'(cmd_addr_q[0]), 64'(32'h0F00));
    chk("chunk1_addr", 64'(cmd_addr_q[1]), 64'(32'h1F00));
    chk("chunk2_addr", 64'(cmd_addr_q[2]), 64'(32'h2F00));
    chk("chunk2_len", 64'(cmd_len_q[2]), 64'(1808));

    // Round-robin with all three requesting
    reset_dut();
    bus.lenin   = 16'd64;
    bus.lenkrnl = 16'd64;
    bus.lenindx = 16'd64;
    bus.req     = 3'b111;
    service(0, 1, 1, 3, 1'b0, 1'b1, 3'b110);
    chk("rr_first", 64'(gnt_seen), 64'(3'b001));
    bus.req = 3'b111;  // bit0 re-raised: must wait behind bit1 and bit2
    service(0, 1, 1, 3, 1'b0, 1'b0, 3'b000);
    chk("rr_second", 64'(gnt_seen), 64'(3'b010));
    service(0, 1, 1, 3, 1'b0, 1'b0, 3'b000);
    chk("rr_third", 64'(gnt_seen), 64'(3'b100));
    service(0, 1, 1, 3, 1'b0, 1'b0, 3'b000);
    chk("rr_fourth", 64'(gnt_seen), 64'(3'b001));

    // Backpressure then zero length
    bus.req      = 3'b100;
    bus.addrindx = 32'h4000;
    bus.lenindx  = 16'd200;
    service(5, 5, 2, 2, 1'b0, 1'b0, 3'b000);
    bus.lenindx = 16'd0;
    service(0, 0, 1, 1, 1'b0, 1'b1, 3'b000);
    chk("zero_ncmd", 64'(cmd_len_q.size()), 64'(0));

    // Address wrap
    bus.req    = 3'b001;
    bus.addrin = 32'hFFFF_F000;
    bus.lenin  = 16'd8192;
    service(0, 1, 1, 4, 1'b0, 1'b1, 3'b000);
    chk("wrap_ncmd", 64'(cmd_len_q.size()), 64'(2));
    chk("wrap_addr", 64'(cmd_addr_q[1]), 64'(32'h0));

    // Reset while waiting for rdlast
    bus.req    = 3'b001;
    bus.addrin = 32'h1234;
    bus.lenin  = 16'd100;
    tick();
    chk("rstw_gnt", 64'(bus.gnt), 64'(3'b001));
    bus.rdready = 1'b1;
    tick();
    chk("rstw_in_wait", 64'(bus.rdvalid), 64'(0));
    bus.rdready = 1'b0;
    rst         = 1'b1;
    tick();
    chk("rstw_gnt0", 64'(bus.gnt), 64'(0));
    chk("rstw_rdvalid0", 64'(bus.rdvalid), 64'(0));
    chk("rstw_busy0", 64'(bus.busy), 64'(0));
    chk("rstw_done0", 64'(bus.done), 64'(0));
    rst         = 1'b0;
    last_owner  = 2;
    bus.req     = 3'b100;
    bus.lenindx = 16'd64;
    service(0, 1, 1, 3, 1'b0, 1'b1, 3'b000);
    chk("rstw_regrant", 64'(gnt_seen), 64'(3'b100));

    // Randomized services
    for (int it = 0; it < 40; it++) begin
      bus.req      = 3'($urandom_range(7, 1));
      bus.addrin   = $urandom;
      bus.addrkrnl = $urandom;
      bus.addrindx = $urandom;
      bus.lenin    = rand_len();
      bus.lenkrnl  = rand_len();
      bus.lenindx  = rand_len();
      service(0, 4, 1, 12, 1'b1, 1'b0, 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dma_rd_arbiter.md
Name: dma_rd_arbiter

Overview:
- Shares the single DMA read-command channel between the three layer-load requesters: input tile, kernel, and sparse index.
- Grants the channel round-robin and issues read commands (rdaddr/transferlen).
- Splits any request longer than MAXLEN into consecutive chunks and waits for each chunk's rdlast.
- Signals per-requester completion so control_top can advance its layer sequencing.

Parameters:
- ADDRLEN, 32, address width.
- LENW, 16, transfer-length width in bytes.
- MAXLEN, 4096, maximum bytes per issued command; 1..2^LENW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- req  in  3  request level; bit0 input, bit1 kernel, bit2 index.
- addrin  in  ADDRLEN  input start address.
- addrkrnl  in  ADDRLEN  kernel start address.
- addrindx  in  ADDRLEN  index start address.
- lenin  in  LENW  input total bytes.
- lenkrnl  in  LENW  kernel total bytes.
- lenindx  in  LENW  index total bytes.
- gnt  out  3  one-hot; the owner during service.
- done  out  3  one-cycle completion pulse to the owner.
- rdvalid  out  1  read command valid.
- rdready  in  1  DMA accepts command.
- rdaddr  out  ADDRLEN  command address.
- transferlen  out  LENW  command length in bytes.
- rdlast  in  1  last beat of the current command's data.
- busy  out  1  high in any state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdvalid=0, rdaddr=0, transferlen=0, busy=0, state=IDLE, priority pointer ptr=0.
- States: IDLE, ISSUE, WAIT, DONE. Encoding 2 bits: 00, 01, 10, 11.
- IDLE
  - If req!=0, select the first set bit scanning ptr, ptr+1, ptr+2 (mod 3).
  - Latch that requester's address into cur_addr and its length into rem.
  - Next cycle: gnt=onehot(sel), busy=1.
  - Next state is DONE if the latched len==0, otherwise ISSUE.
- ISSUE
  - rdvalid=1, rdaddr=cur_addr, transferlen=min(rem, MAXLEN).
  - Hold all command fields stable until rdvalid&rdready.
  - On that handshake: rdvalid=0 next cycle, go to WAIT.
- WAIT
  - On rdlast: rem -= chunk and cur_addr += chunk, where chunk is the transferlen just issued.
  - Address addition is modulo 2^ADDRLEN; wrap is allowed, with no error.
  - If the new rem==0, go to DONE; otherwise go to ISSUE. The next rdvalid rises the cycle after rdlast.
- DONE (exactly one cycle)
  - done[sel]=1 and gnt stays asserted.
  - Next cycle: gnt=0, done=0, busy=0, ptr=(sel+1) mod 3, state=IDLE.
- Latency:
  - Request sampled in IDLE at cycle t gives gnt and rdvalid at t+1.
  - Zero-length request gives done at t+1.
  - Two back-to-back requesters: the second gnt appears 2 cycles after the first done.
- The owner's req is ignored from grant until IDLE.
  - Deasserting req mid-service does not abort the service.
  - req still high during the DONE cycle is not re-sampled until IDLE. A requester keeping req high gets re-served only after the others have had their turn.
- Address and length inputs are sampled only at grant; later changes have no effect on the service in progress.
- rdlast outside WAIT is ignored.
- rdready with rdvalid=0 is ignored.
- rdlast arriving in the same cycle as the ISSUE handshake is not counted; the DMA must not do this.
- Simultaneous requests are resolved by ptr only; there is no fixed priority.
- Reset mid-operation (any state): all outputs reach reset values the next cycle. The outstanding command is abandoned and the system is reset as a whole.
- Exactly one gnt bit is high when busy=1; gnt=0 when busy=0.

Test Plan:
- Basic input load
  - Stimulus: after reset, req=001, addrin=0x0, lenin=1000. DMA holds rdready=1 and pulses rdlast 10 cycles after acceptance.
  - Required: gnt=001 at t+1; one command with rdaddr=0x0, transferlen=1000; done=001 for one cycle; busy returns to 0.
- Chunking
  - Stimulus: req=010, addrkrnl=0xF00, lenkrnl=10000, MAXLEN=4096.
  - Required: commands (0xF00, 4096), (0x1F00, 4096), (0x2F00, 1808), each issued only after the previous rdlast; then done=010.
- Round-robin
  - Stimulus: req=111 held continuously, every len=64.
  - Required: grant order 001, 010, 100, 001. After ptr advances, a newly re-raised bit0 must not pre-empt bit1 or bit2.
- Backpressure and zero length
  - Stimulus: rdready held low 5 cycles during ISSUE; then a separate request with lenindx=0.
  - Required: rdaddr/transferlen stable and rdvalid high throughout the stall. The zero-length request gives done=100 at t+1 with no rdvalid.
- Address wrap and reset
  - Stimulus: addrin=0xFFFFF000, lenin=8192.
  - Required: second command at rdaddr=0x00000000.
  - Stimulus: rst asserted in WAIT.
  - Required: next cycle gnt=0, rdvalid=0, busy=0; a fresh req=100 is then granted.
